// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: power-of-two depth, synchronous clear.
// A push in the clear cycle lands as the sole entry of the emptied buffer.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clr,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_rd <= '0;
            if (i_push) begin
                r_mem[0] <= i_data;
                r_wr     <= AW'(1);
                r_count  <= CW'(1);
            end else begin
                r_wr    <= '0;
                r_count <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (i_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests, in-order responses, redirect flush.
// Optional macro FETCH_MISALIGN_EXC_EN adds o_if_misaligned and misaligned-target trapping.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [XLEN-1:0]   o_imem_addr,
    input  logic              i_imem_rsp_valid,
    input  logic [31:0]       i_imem_rsp_data,
    output logic              o_if_valid,
    input  logic              i_if_ready,
    output logic [31:0]       o_if_instruction,
    output logic [XLEN-1:0]   o_if_pc,
    input  logic              i_redirect_valid,
    input  logic [XLEN-1:0]   i_redirect_pc,
`ifdef FETCH_MISALIGN_EXC_EN
    output logic              o_if_misaligned,
`endif
    output fetch_state_e      o_dbg_state
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef FETCH_MISALIGN_EXC_EN
    localparam int PW = XLEN + 32 + 1;
`else
    localparam int PW = XLEN + 32;
`endif

    logic [XLEN-1:0] r_pc;
    fetch_state_e    r_state;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   r_stale;
    logic [XLEN-1:0] r_pcq [FIFO_DEPTH];
    logic [AW-1:0]   r_pcq_wr;
    logic [AW-1:0]   r_pcq_rd;

    logic [XLEN-1:0] w_redirect_pc;
    logic [CW-1:0]   w_fifo_count;
    logic [CW:0]     w_inflight;
    logic            w_credit;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_live;
    logic            w_rsp_stale;
    logic [CW-1:0]   w_stale_next;
    logic            w_push;
    logic [PW-1:0]   w_push_data;
    logic            w_pop;
    logic            w_fifo_empty;
    logic [PW-1:0]   w_head;
    logic            w_halt;

`ifdef FETCH_MISALIGN_EXC_EN
    logic r_halt;
    logic w_misalign;
    assign w_misalign    = i_redirect_valid & (i_redirect_pc[1:0] != 2'b00);
    assign w_redirect_pc = i_redirect_pc;
    assign w_halt        = r_halt;
`else
    assign w_redirect_pc = i_redirect_pc & ~XLEN'(3);
    assign w_halt        = 1'b0;
`endif

    // Credit counts every in-flight request, so a buffered slot always exists for its response.
    assign w_inflight  = {1'b0, r_out} + {1'b0, w_fifo_count};
    assign w_credit    = w_inflight < (CW+1)'(FIFO_DEPTH);
    assign w_req_valid = i_rst_n & (r_state == ST_FETCH) & !i_redirect_valid & w_credit & !w_halt;
    assign w_req_fire  = w_req_valid & i_imem_req_ready;
    assign w_rsp_stale = i_imem_rsp_valid & (r_stale != '0);
    assign w_rsp_live  = i_imem_rsp_valid & (r_stale == '0);

    always_comb begin
        w_stale_next = r_stale;
        if (i_redirect_valid) begin
            w_stale_next = r_out - CW'(i_imem_rsp_valid);
        end else if (w_rsp_stale) begin
            w_stale_next = r_stale - CW'(1);
        end
    end

`ifdef FETCH_MISALIGN_EXC_EN
    assign w_push      = (w_rsp_live & !i_redirect_valid) | w_misalign;
    assign w_push_data = w_misalign ? {i_redirect_pc, NOP_INSTR, 1'b1}
                                    : {r_pcq[r_pcq_rd], i_imem_rsp_data, 1'b0};
`else
    assign w_push      = w_rsp_live & !i_redirect_valid;
    assign w_push_data = {r_pcq[r_pcq_rd], i_imem_rsp_data};
`endif

    assign w_pop = o_if_valid & i_if_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // The PC queue pops on every response, stale or not, to stay aligned with memory order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc     <= RESET_PC;
            r_state  <= ST_FETCH;
            r_out    <= '0;
            r_stale  <= '0;
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_pcq[i] <= '0;
            end
`ifdef FETCH_MISALIGN_EXC_EN
            r_halt   <= 1'b0;
`endif
        end else begin
            if (w_req_fire) begin
                r_pcq[r_pcq_wr] <= r_pc;
                r_pcq_wr        <= r_pcq_wr + AW'(1);
            end
            if (i_imem_rsp_valid) begin
                r_pcq_rd <= r_pcq_rd + AW'(1);
            end
            r_out   <= r_out + CW'(w_req_fire) - CW'(i_imem_rsp_valid);
            r_stale <= w_stale_next;
            if (i_redirect_valid) begin
                r_pc <= w_redirect_pc;
`ifdef FETCH_MISALIGN_EXC_EN
                r_halt <= w_misalign;
`endif
            end else if (w_req_fire) begin
                r_pc <= r_pc + XLEN'(4);
            end
            case (r_state)
                ST_FETCH: if (i_redirect_valid && (w_stale_next != '0)) r_state <= ST_FLUSH;
                ST_FLUSH: if (w_stale_next == '0) r_state <= ST_FETCH;
                default:  r_state <= ST_FETCH;
            endcase
        end
    end

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_addr      = r_pc;
    assign o_if_valid       = !w_fifo_empty & !i_redirect_valid;
    assign o_if_pc          = w_head[PW-1 -: XLEN];
    assign o_if_instruction = w_head[PW-XLEN-1 -: 32];
`ifdef FETCH_MISALIGN_EXC_EN
    assign o_if_misaligned  = w_head[0];
`endif
    assign o_dbg_state      = r_state;

endmodule
